// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types.
// State and grant encodings plus counter sizing.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic {
    GNT_FETCH,
    GNT_DATA
  } gnt_e;

  function automatic int cnt_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for fetch and data
// requesters sharing one fixed-latency memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_enable,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = cnt_w(LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  state_e        state_q, state_d;
  gnt_e          gnt_q, gnt_d;
  gnt_e          last_q, last_d;
  gnt_e          gnt_sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          f_ack_q, f_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] f_rdata_q, f_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          en_q, en_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  // Next-state, grant selection and registered output values.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    f_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    en_d      = en_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    gnt_sel   = GNT_FETCH;
    if (f_req && d_req) begin
      gnt_sel = (last_q == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
    end else if (d_req) begin
      gnt_sel = GNT_DATA;
    end
    unique case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          state_d = BUSY;
          gnt_d   = gnt_sel;
          last_d  = gnt_sel;
          cnt_d   = CNT_LOAD;
          en_d    = 1'b1;
          wr_d    = d_wr && (gnt_sel == GNT_DATA);
          addr_d  = (gnt_sel == GNT_DATA) ? d_addr : f_addr;
          wdata_d = d_wdata;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          en_d    = 1'b0;
          wr_d    = 1'b0;
          if (gnt_q == GNT_FETCH) begin
            f_ack_d   = 1'b1;
            f_rdata_d = mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!wr_q) d_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; async reset drops the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_FETCH;
      last_q    <= GNT_FETCH;
      cnt_q     <= '0;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      en_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      f_ack_q   <= f_ack_d;
      d_ack_q   <= d_ack_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
      en_q      <= en_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign f_ack      = f_ack_q;
  assign d_ack      = d_ack_q;
  assign f_rdata    = f_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign mem_enable = en_q;
  assign mem_wr     = wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at
// LATENCY=4 and LATENCY=1.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        f_req, d_req, d_wr;
  logic [15:0] f_addr, d_addr, d_wdata;
  logic        f_ack, d_ack, mem_enable, mem_wr;
  logic [15:0] f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        g_f_req;
  logic [15:0] g_f_addr;
  logic        g_f_ack, g_d_ack, g_en, g_wr;
  logic [15:0] g_f_rdata, g_d_rdata, g_addr, g_wdata, g_rdata;

  int checks = 0;
  int failures = 0;

  function automatic logic [15:0] rd(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hA5A5 : (a ^ 16'h5A00);
  endfunction

  assign mem_rdata = rd(mem_addr);
  assign g_rdata   = rd(g_addr);

  mem_arbiter #(.LATENCY(4), .AW(16), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr),
    .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.LATENCY(1), .AW(16), .DW(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .f_req(g_f_req), .f_addr(g_f_addr),
    .f_ack(g_f_ack), .f_rdata(g_f_rdata),
    .d_req(1'b0), .d_wr(1'b0),
    .d_addr(16'h0000), .d_wdata(16'h0000),
    .d_ack(g_d_ack), .d_rdata(g_d_rdata),
    .mem_enable(g_en), .mem_wr(g_wr),
    .mem_addr(g_addr), .mem_wdata(g_wdata),
    .mem_rdata(g_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    f_req = 1'b0;
    d_req = 1'b0;
    d_wr  = 1'b0;
    g_f_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    f_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    g_f_req = 1'b0; g_f_addr = '0;
    tick();
    check("rst_en", mem_enable, 0);
    check("rst_wr", mem_wr, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_fack", f_ack, 0);
    check("rst_dack", d_ack, 0);
    check("rst_frd", f_rdata, 0);
    check("rst_drd", d_rdata, 0);
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("idle_en_c%0d", c), mem_enable, 0);
    end

    // lone fetch; address change mid-access ignored
    f_addr = 16'h0010;
    f_req  = 1'b1;
    check("f_c0_en", mem_enable, 0);
    for (int c = 1; c <= 7; c++) begin
      tick();
      check($sformatf("f_en_c%0d", c), mem_enable, 32'(c <= 4));
      check($sformatf("f_wr_c%0d", c), mem_wr, 0);
      check($sformatf("f_ack_c%0d", c), f_ack, 32'(c == 5));
      if (c <= 4) check($sformatf("f_addr_c%0d", c), mem_addr, 16'h0010);
      if (c == 2) f_addr = 16'hFFFF;
      if (c == 5) begin
        check("f_rdata", f_rdata, 16'hA5A5);
        f_req = 1'b0;
      end
    end

    // data write
    d_addr = 16'h0200; d_wdata = 16'h1234;
    d_wr = 1'b1; d_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("w_en_c%0d", c), mem_enable, 32'(c <= 4));
      check($sformatf("w_wr_c%0d", c), mem_wr, 32'(c <= 4));
      check($sformatf("w_dack_c%0d", c), d_ack, 32'(c == 5));
      check($sformatf("w_fack_c%0d", c), f_ack, 0);
      if (c <= 4) begin
        check($sformatf("w_addr_c%0d", c), mem_addr, 16'h0200);
        check($sformatf("w_wd_c%0d", c), mem_wdata, 16'h1234);
      end
      if (c == 5) begin
        check("w_drd_keep", d_rdata, 0);
        d_req = 1'b0; d_wr = 1'b0;
      end
    end

    // data read
    d_addr = 16'h0300; d_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("r_en_c%0d", c), mem_enable, 32'(c <= 4));
      check($sformatf("r_wr_c%0d", c), mem_wr, 0);
      check($sformatf("r_dack_c%0d", c), d_ack, 32'(c == 5));
      if (c == 5) begin
        check("r_drd", d_rdata, 16'h5900);
        check("r_frd_keep", f_rdata, 16'hA5A5);
        d_req = 1'b0;
      end
    end

    // tie out of reset: data wins first
    do_reset();
    f_addr = 16'h0020; d_addr = 16'h0040; d_wr = 1'b0;
    f_req = 1'b1; d_req = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      check($sformatf("t_en_c%0d", c), mem_enable,
            32'((c >= 1 && c <= 4) || (c >= 7 && c <= 10)));
      check($sformatf("t_dack_c%0d", c), d_ack, 32'(c == 5));
      check($sformatf("t_fack_c%0d", c), f_ack, 32'(c == 11));
      if (c <= 4) check($sformatf("t_addr_c%0d", c), mem_addr, 16'h0040);
      if (c >= 7 && c <= 10)
        check($sformatf("t_addr_c%0d", c), mem_addr, 16'h0020);
      if (c == 5) begin
        check("t_drd", d_rdata, 16'h5A40);
        d_req = 1'b0;
      end
      if (c == 11) begin
        check("t_frd", f_rdata, 16'h5A20);
        f_req = 1'b0;
      end
    end
    tick();

    // continuous dual requests: D,F,D,F...
    f_addr = 16'h0100; d_addr = 16'h0400;
    f_req = 1'b1; d_req = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      int p, n;
      tick();
      p = (c - 1) % 6;
      n = (c - 1) / 6;
      check($sformatf("rr_en_c%0d", c), mem_enable, 32'(p < 4));
      check($sformatf("rr_dack_c%0d", c), d_ack,
            32'(p == 4 && (n % 2) == 0));
      check($sformatf("rr_fack_c%0d", c), f_ack,
            32'(p == 4 && (n % 2) == 1));
      if (p < 4)
        check($sformatf("rr_addr_c%0d", c), mem_addr,
              ((n % 2) == 0) ? 16'h0400 : 16'h0100);
    end
    f_req = 1'b0; d_req = 1'b0;
    tick();

    // reset in cycle 2 of a fetch
    f_addr = 16'h0030; f_req = 1'b1;
    tick();
    tick();
    check("mr_en_c2", mem_enable, 1);
    #3 rst_n = 1'b0;
    #1;
    check("mr_en_async", mem_enable, 0);
    check("mr_addr_async", mem_addr, 0);
    check("mr_frd_async", f_rdata, 0);
    check("mr_drd_async", d_rdata, 0);
    repeat (2) begin
      tick();
      check("mr_fack_held", f_ack, 0);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("mr_en_c%0d", c), mem_enable, 32'(c <= 4));
      check($sformatf("mr_fack_c%0d", c), f_ack, 32'(c == 5));
      if (c <= 4) check($sformatf("mr_addr_c%0d", c), mem_addr, 16'h0030);
      if (c == 5) begin
        check("mr_frd", f_rdata, 16'h5A30);
        f_req = 1'b0;
      end
    end

    // LATENCY=1: one BUSY cycle
    g_f_addr = 16'h0010; g_f_req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("l1_en_c%0d", c), g_en, 32'(c == 1));
      check($sformatf("l1_fack_c%0d", c), g_f_ack, 32'(c == 2));
      if (c == 1) check("l1_addr", g_addr, 16'h0010);
      if (c == 2) begin
        check("l1_frd", g_f_rdata, 16'hA5A5);
        g_f_req = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
